core_alu_seq: RTL and testbench
===============================

CORE_ALU_SEQ -- requirements
Module: core_alu_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst_n.
REQ-002 Parameter W SHALL default to 16, be the operand/result width, and be a power of two, at least 4.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous reset, active-high despite the name.
REQ-005 start  in  1  request; accepted when start=1 and ready=1 at a rising edge.
REQ-006 op  in  4  encoding: 1 AND, 2 ORR, 3 XOR, 4 SHL, 5 SHR, 6 ADD, 7 SUB, 8 ASR, 9 ROR, 10 MUL, 11 MULH; all others reserved.
REQ-007 a, b  in  W  operands; sampled only at the accept edge.
REQ-008 ready  out  1  high when a request can be accepted.
REQ-009 done  out  1  one-cycle pulse; q, flags and err are valid in that cycle.
REQ-010 q  out  W  result.
REQ-011 flags  out  4  {N,Z,C,V}.
REQ-012 err  out  1  the completed op was reserved.

Function
REQ-013 The state machine SHALL have three states: IDLE, MUL and DONE.
REQ-014 State transitions SHALL be:
- IDLE/DONE + accept of op 10/11 -> MUL.
- IDLE/DONE + accept of any other op -> DONE.
- DONE with no accept -> IDLE.
- MUL with counter=0 -> DONE.
REQ-015 ready SHALL equal (state != MUL), so back-to-back accepts from DONE are allowed.
REQ-016 done SHALL equal (state == DONE).
REQ-017 Latency for non-MUL ops SHALL be: accept at edge k -> done=1 in cycle k+1.
REQ-018 Latency for MUL/MULH SHALL be: accept at edge k -> done=1 in cycle k+W+1.
- Implementation is iterative shift-add, one multiplier bit per cycle, with a counter loaded with W-1.
REQ-019 start while ready=0 SHALL be ignored, with no queuing and no effect on the operation in flight.
REQ-020 Operands and op SHALL be latched at accept; input changes afterwards SHALL NOT affect the result.
REQ-021 Logic ops SHALL be bitwise; ADD/SUB SHALL be modulo 2^W.
REQ-022 Shifts SHALL use the unsigned amount s = b:
- SHL and SHR give 0 for s >= W.
- ASR sign-fills; for s >= W the result is all copies of a[W-1].
- ROR rotates right by s mod W.
REQ-023 MUL SHALL return the low W bits of the unsigned 2W-bit product; MULH SHALL return the high W bits.
REQ-024 N and Z SHALL be set for every op: N = q[W-1], Z = (q == 0).
REQ-025 C SHALL be set as follows (0 for all other ops):
- ADD: carry out.
- SUB: 1 iff a >= b unsigned, i.e. no borrow.
- SHL: last bit shifted out; 0 when s=0 or s > W.
- SHR/ASR: last bit shifted out; 0 when s=0; for s > W, SHR gives 0 and ASR gives a[W-1].
- MUL: 1 iff the high half is non-zero.
REQ-026 V SHALL be signed overflow for ADD/SUB and 0 otherwise.
REQ-027 A reserved op SHALL give q=0, flags=0100 (Z=1), err=1, with 1-cycle latency.
REQ-028 q, flags and err SHALL hold their last value until the next done.

Reset
REQ-029 While rst_n=1, the block SHALL be held in reset with: state=IDLE, ready=1, done=0, q=0, flags=0, err=0, counter=0.
REQ-030 Reset asserted mid-MUL SHALL abort the operation, with no done pulse for it.
REQ-031 An accept SHALL be possible at the first rising edge after rst_n falls.

Verification (W=16)
REQ-032 ADD a=0x7FFF b=0x0001, accepted at edge k -> cycle k+1: done=1, q=0x8000, flags N1 Z0 C0 V1.
REQ-033 SUB a=0x0005 b=0x0005 -> q=0x0000, flags N0 Z1 C1 V0; a second SUB accepted in the DONE cycle -> done again in the next cycle.
REQ-034 MUL a=0x1234 b=0x0100 at edge k; start re-asserted at k+3 with op=ADD -> the ADD is ignored; ready=0 for cycles k+1..k+16; done only at k+17 with q=0x3400, C=1.
REQ-035 MULH a=0xFFFF b=0xFFFF -> q=0xFFFE, N=1; MUL with the same operands -> q=0x0001, C=1.
REQ-036 Shift checks:
- ASR 0x8000 by 20 -> q=0xFFFF, C=1.
- ROR 0x0001 by 17 -> q=0x8000.
- SHL 0x8001 by 1 -> q=0x0002, C=1.
- SHR 0x0003 by 16 -> q=0x0000, Z=1, C=0.
REQ-037 Abort and reserved op:
- MUL accepted at k, rst_n pulsed at k+5 -> no done pulse; ready=1, q=0 after reset.
- Reserved op 0xF -> done at k+1 with q=0, err=1, Z=1.

Source files
------------

// File: rtl/core_alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus an iterative
// shift-add multiplier (MUL/MULH) taking W cycles, with N/Z/C/V flags.
module core_alu_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] q,
  output logic [3:0]   flags,
  output logic         err,
  output logic [1:0]   dbg_state
);

  // Handshake: a request is taken on a rising edge where start=1 and ready=1;
  // start with ready=0 is dropped. done is a one-cycle pulse and q/flags/err
  // are valid during it, then hold until the next done.

  localparam int LW = $clog2(W);

  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_ORR  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_ADD  = 4'd6;
  localparam logic [3:0] OP_SUB  = 4'd7;
  localparam logic [3:0] OP_ASR  = 4'd8;
  localparam logic [3:0] OP_ROR  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_MULH = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic          accept;
  logic          is_mul;
  logic [LW-1:0] cnt;
  logic [W-1:0]  mcand;
  logic [W-1:0]  acc_hi;
  logic [W-1:0]  acc_lo;
  logic          mulh_r;

  logic [W-1:0]  alu_q;
  logic          alu_c;
  logic          alu_v;
  logic          alu_err;
  logic [W:0]    add_tmp;
  logic [W:0]    sub_tmp;
  logic [W:0]    shl_tmp;
  logic [W:0]    shr_tmp;
  logic signed [W:0] asr_tmp;
  logic [W-1:0]  ror_q;
  logic [LW-1:0] ror_idx;

  logic [W:0]    mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W-1:0]  mul_res;
  logic          mul_c;

  assign accept = start & ready;
  assign is_mul = (op == OP_MUL) || (op == OP_MULH);

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) state_nxt = is_mul ? S_MUL : S_DONE;
        else        state_nxt = S_IDLE;
      end
      S_MUL:   if (cnt == '0) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready     = (state != S_MUL);
    done      = (state == S_DONE);
    dbg_state = state;
  end

  // Single-cycle datapath, evaluated on the live inputs at the accept edge
  always_comb begin
    add_tmp = {1'b0, a} + {1'b0, b};
    sub_tmp = {1'b0, a} - {1'b0, b};
    // The extra bit beyond the operand catches the last bit shifted out.
    shl_tmp = {1'b0, a} << b;
    shr_tmp = {a, 1'b0} >> b;
    asr_tmp = $signed({a, 1'b0}) >>> b;
    ror_q   = '0;
    ror_idx = '0;
    for (int i = 0; i < W; i++) begin
      ror_idx  = LW'(i) + b[LW-1:0];
      ror_q[i] = a[ror_idx];
    end

    alu_q   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op)
      OP_AND: alu_q = a & b;
      OP_ORR: alu_q = a | b;
      OP_XOR: alu_q = a ^ b;
      OP_SHL: begin alu_q = shl_tmp[W-1:0]; alu_c = shl_tmp[W]; end
      OP_SHR: begin alu_q = shr_tmp[W:1];   alu_c = shr_tmp[0]; end
      OP_ASR: begin alu_q = asr_tmp[W:1];   alu_c = asr_tmp[0]; end
      OP_ROR: alu_q = ror_q;
      OP_ADD: begin
        alu_q = add_tmp[W-1:0];
        alu_c = add_tmp[W];
        alu_v = (a[W-1] == b[W-1]) && (add_tmp[W-1] != a[W-1]);
      end
      OP_SUB: begin
        alu_q = sub_tmp[W-1:0];
        alu_c = ~sub_tmp[W];
        alu_v = (a[W-1] != b[W-1]) && (sub_tmp[W-1] != a[W-1]);
      end
      OP_MUL, OP_MULH: alu_q = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // One shift-add step: {acc_hi, acc_lo} holds partial product and the
  // not-yet-consumed multiplier bits.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    mul_next = {mul_sum, acc_lo[W-1:1]};
    mul_res  = mulh_r ? mul_next[2*W-1:W] : mul_next[W-1:0];
    mul_c    = ~mulh_r & (|mul_next[2*W-1:W]);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt    <= '0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mulh_r <= 1'b0;
      q      <= '0;
      flags  <= '0;
      err    <= 1'b0;
    end else if (accept) begin
      if (is_mul) begin
        mcand  <= a;
        acc_hi <= '0;
        acc_lo <= b;
        mulh_r <= (op == OP_MULH);
        cnt    <= LW'(W - 1);
      end else begin
        q     <= alu_q;
        flags <= {alu_q[W-1], (alu_q == '0), alu_c, alu_v};
        err   <= alu_err;
      end
    end else if (state == S_MUL) begin
      acc_hi <= mul_next[2*W-1:W];
      acc_lo <= mul_next[W-1:0];
      if (cnt == '0) begin
        q     <= mul_res;
        flags <= {mul_res[W-1], (mul_res == '0), mul_c, 1'b0};
        err   <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_core_alu_seq.sv
// Directed bench for core_alu_seq (W=16): vector table plus multi-cycle
// sequences for busy-time starts, reset abort and post-reset accept.
module tb_core_alu_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready;
  logic         done;
  logic [W-1:0] q;
  logic [3:0]   flags;
  logic         err;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  core_alu_seq #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .done(done), .q(q), .flags(flags), .err(err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eq;
    logic [3:0]   ef;
    logic         ee;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or timeout).
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int exp_lat;
    logic [W-1:0] e;
    exp_lat = (v.op == 4'd10 || v.op == 4'd11) ? W + 1 : 1;
    exp_q.push_back(v.eq);
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 4'($urandom_range(0, 15));
    a = W'($urandom_range(0, 65535));
    b = W'($urandom_range(0, 65535));
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    e = exp_q.pop_front();
    if (!done) begin
      chk($sformatf("vec%0d_timeout", idx), 32'(done), 32'd1);
    end else begin
      chk($sformatf("vec%0d_latency", idx), 32'(lat), 32'(exp_lat));
      chk($sformatf("vec%0d_q", idx), 32'(q), 32'(e));
      chk($sformatf("vec%0d_flags", idx), 32'(flags), 32'(v.ef));
      chk($sformatf("vec%0d_err", idx), 32'(err), 32'(v.ee));
    end
  endtask

  initial begin
    int nd;
    logic [W-1:0] hold_q;

    // op, a, b, q, {N,Z,C,V}, err
    vecs[0]  = '{4'd6,  16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1'b0};
    vecs[1]  = '{4'd7,  16'h0005, 16'h0005, 16'h0000, 4'b0110, 1'b0};
    vecs[2]  = '{4'd7,  16'h0005, 16'h0005, 16'h0000, 4'b0110, 1'b0};
    vecs[3]  = '{4'd1,  16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000, 1'b0};
    vecs[4]  = '{4'd2,  16'h0F00, 16'h00F0, 16'h0FF0, 4'b0000, 1'b0};
    vecs[5]  = '{4'd3,  16'hFFFF, 16'h00FF, 16'hFF00, 4'b1000, 1'b0};
    vecs[6]  = '{4'd4,  16'h8001, 16'h0001, 16'h0002, 4'b0010, 1'b0};
    vecs[7]  = '{4'd5,  16'h0003, 16'h0010, 16'h0000, 4'b0100, 1'b0};
    vecs[8]  = '{4'd8,  16'h8000, 16'h0014, 16'hFFFF, 4'b1010, 1'b0};
    vecs[9]  = '{4'd9,  16'h0001, 16'h0011, 16'h8000, 4'b1000, 1'b0};
    vecs[10] = '{4'd10, 16'h1234, 16'h0100, 16'h3400, 4'b0010, 1'b0};
    vecs[11] = '{4'd11, 16'hFFFF, 16'hFFFF, 16'hFFFE, 4'b1000, 1'b0};
    vecs[12] = '{4'd10, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0010, 1'b0};
    vecs[13] = '{4'd6,  16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1'b0};
    vecs[14] = '{4'd7,  16'h0003, 16'h0005, 16'hFFFE, 4'b1000, 1'b0};
    vecs[15] = '{4'd7,  16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 1'b0};
    vecs[16] = '{4'd15, 16'h1234, 16'h5678, 16'h0000, 4'b0100, 1'b1};
    vecs[17] = '{4'd0,  16'hFFFF, 16'hFFFF, 16'h0000, 4'b0100, 1'b1};
    vecs[18] = '{4'd4,  16'h0001, 16'h0010, 16'h0000, 4'b0110, 1'b0};
    vecs[19] = '{4'd8,  16'h4000, 16'h0000, 16'h4000, 4'b0000, 1'b0};
    vecs[20] = '{4'd9,  16'h1234, 16'h0004, 16'h4123, 4'b0000, 1'b0};
    vecs[21] = '{4'd5,  16'h8000, 16'h0010, 16'h0000, 4'b0110, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // Release reset and accept on the very next rising edge
    rst_n = 1'b0;
    run_vec(vecs[0], 0);

    // Table, chained back-to-back (each accept lands in the DONE cycle)
    for (int i = 1; i < 22; i++) run_vec(vecs[i], i);

    // DONE without accept falls to IDLE; outputs hold
    hold_q = q;
    repeat (3) @(negedge clk);
    chk("hold_done", 32'(done), 32'd0);
    chk("hold_q", 32'(q), 32'(hold_q));
    chk("hold_flags", 32'(flags), 32'b0110);

    // MUL with an ADD start during the busy window that must be ignored
    start = 1'b1; op = 4'd10; a = 16'h1234; b = 16'h0100;
    @(posedge clk);
    #1 start = 1'b0;
    nd = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 3) begin start = 1'b1; op = 4'd6; a = 16'h0001; b = 16'h0001; end
      if (c == 4) start = 1'b0;
      if (ready !== 1'b0) nd++;
      if (done !== 1'b0) nd++;
    end
    chk("busy_ready_done_low", 32'(nd), 32'd0);
    @(negedge clk);
    chk("busy_mul_done", 32'(done), 32'd1);
    chk("busy_mul_q", 32'(q), 32'h3400);
    chk("busy_mul_c", 32'(flags[1]), 32'd1);
    @(negedge clk);
    chk("busy_no_queued_done", 32'(done), 32'd0);
    chk("busy_no_queued_q", 32'(q), 32'h3400);

    // Abort a MUL with reset
    start = 1'b1; op = 4'd10; a = 16'hFFFF; b = 16'hFFFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy", 32'(ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    nd = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    chk("abort_ready_after", 32'(ready), 32'd1);
    chk("abort_q_after", 32'(q), 32'd0);

    // Reserved op after abort
    run_vec(vecs[16], 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
